// File: rtl/jt12_wrqueue.sv
// jt12_wrqueue
// Write queue and bus sequencer that sits in front of the jt12 core.
// The CPU pushes register writes into a small FIFO, one entry per cycle.
// A sequencer replays each entry onto the jt12 bus pins. Before every
// data-port write it polls the status byte until the busy bit clears, so
// the CPU never has to poll busy itself. Runs on the jt12 clock.
//
// Ports:
//   clk, rst            clock and asynchronous active-high reset
//   cpu_wr              push strobe, one entry per high cycle
//   cpu_addr, cpu_din   jt12 address (bit0=1 selects the data port) and data
//   full, empty, level  FIFO status (level counts queued entries)
//   drop                one-cycle pulse, a push was rejected because the FIFO was full
//   timeout             one-cycle pulse, a write was forced after the busy poll gave up
//   idle                FIFO empty and sequencer idle
//   ym_addr, ym_din     jt12 addr / din
//   ym_cs_n, ym_wr_n    jt12 chip select / write strobe (active low)
//   ym_dout             jt12 status byte, bit7 = busy
module jt12_wrqueue #(
  parameter int DEPTH_LOG2   = 4,
  parameter int WR_PULSE     = 2,
  parameter int POLL_WAIT    = 2,
  parameter int BUSY_TIMEOUT = 1023
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_wr,
  input  logic [1:0]          cpu_addr,
  input  logic [7:0]          cpu_din,
  output logic                full,
  output logic                empty,
  output logic [DEPTH_LOG2:0] level,
  output logic                drop,
  output logic                timeout,
  output logic                idle,
  output logic [1:0]          ym_addr,
  output logic [7:0]          ym_din,
  output logic                ym_cs_n,
  output logic                ym_wr_n,
  input  logic [7:0]          ym_dout
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] ONE_LEVEL  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [3:0]  POLL_LAST  = 4'(POLL_WAIT - 1);
  localparam logic [3:0]  PULSE_LAST = 4'(WR_PULSE - 1);
  localparam logic [15:0] BUSY_LIMIT = 16'(BUSY_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    POLL  = 2'd1,
    WRITE = 2'd2,
    GAP   = 2'd3
  } state_t;

  logic [9:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   count, count_nxt;
  logic                  push_ok, pop;

  state_t                state, state_nxt;
  logic [3:0]            cnt, cnt_nxt;
  logic [15:0]           poll_timer, poll_timer_nxt;
  logic [9:0]            entry, entry_nxt;
  logic                  timeout_nxt;

  // Only the busy flag of the status byte matters here.
  logic                  dout_unused;
  assign dout_unused = ^ym_dout[6:0];

  // The full test looks at the pre-pop occupancy, so a push that lands
  // while full is dropped even if the sequencer pops in the same cycle.
  assign push_ok = cpu_wr && (count != FULL_LEVEL);
  assign level   = count;

  // Occupancy after this cycle's push and pop.
  always_comb begin
    count_nxt = count;
    case ({push_ok, pop})
      2'b10:   count_nxt = count + ONE_LEVEL;
      2'b01:   count_nxt = count - ONE_LEVEL;
      default: count_nxt = count;
    endcase
  end

  // FIFO storage, entries packed as {addr, din}. Storage needs no reset;
  // the pointers define which words are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {cpu_addr, cpu_din};
  end

  // Sequencer next-state logic. The shared counter times both the status
  // read window (POLL) and the write strobe width (WRITE); it is cleared
  // whenever one of those windows starts.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    poll_timer_nxt = poll_timer;
    entry_nxt      = entry;
    pop            = 1'b0;
    timeout_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop       = 1'b1;
          entry_nxt = mem[rd_ptr];
          cnt_nxt   = '0;
          if (mem[rd_ptr][8]) begin
            poll_timer_nxt = '0;
            state_nxt      = POLL;
          end else begin
            state_nxt = WRITE;
          end
        end
      end
      POLL: begin
        if (cnt == POLL_LAST) begin
          cnt_nxt = '0;
          if (!ym_dout[7]) begin
            state_nxt = WRITE;
          end else if (poll_timer < BUSY_LIMIT) begin
            poll_timer_nxt = poll_timer + 16'd1;
          end else begin
            timeout_nxt = 1'b1;
            state_nxt   = WRITE;
          end
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      WRITE: begin
        if (cnt == PULSE_LAST) begin
          cnt_nxt   = '0;
          state_nxt = GAP;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      GAP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // All state and every output is registered. Bus pins are driven from the
  // next state so they line up with the cycle the sequencer is actually in.
  // ym_addr/ym_din only move when a POLL or WRITE window opens, which keeps
  // them stable across the whole strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      state      <= IDLE;
      cnt        <= '0;
      poll_timer <= '0;
      entry      <= '0;
      full       <= 1'b0;
      empty      <= 1'b1;
      idle       <= 1'b1;
      drop       <= 1'b0;
      timeout    <= 1'b0;
      ym_addr    <= 2'b00;
      ym_din     <= 8'h00;
      ym_cs_n    <= 1'b1;
      ym_wr_n    <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count      <= count_nxt;
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      poll_timer <= poll_timer_nxt;
      entry      <= entry_nxt;
      full       <= (count_nxt == FULL_LEVEL);
      empty      <= (count_nxt == '0);
      idle       <= (count_nxt == '0) && (state_nxt == IDLE);
      drop       <= cpu_wr && (count == FULL_LEVEL);
      timeout    <= timeout_nxt;
      ym_cs_n    <= !((state_nxt == POLL) || (state_nxt == WRITE));
      ym_wr_n    <= !(state_nxt == WRITE);
      if (state != POLL && state_nxt == POLL) begin
        ym_addr <= 2'b00;
        ym_din  <= entry_nxt[7:0];
      end else if (state != WRITE && state_nxt == WRITE) begin
        ym_addr <= entry_nxt[9:8];
        ym_din  <= entry_nxt[7:0];
      end
    end
  end

endmodule

// File: tb/tb_jt12_wrqueue.sv
// tb_jt12_wrqueue
// Self-checking bench for jt12_wrqueue. Stimulus pushes the expected bus
// transaction into a scoreboard queue; a monitor reassembles each bus
// transaction from the pins and compares it with the queue head. A small
// jt12 status model holds busy for a chosen number of samples per data write.
module tb_jt12_wrqueue;

  localparam int DL    = 4;
  localparam int WP    = 2;
  localparam int PW    = 2;
  localparam int BT    = 12;
  localparam int DEPTH = 1 << DL;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_wr;
  logic [1:0]  cpu_addr;
  logic [7:0]  cpu_din;
  logic        full, empty, drop, timeout, idle;
  logic [DL:0] level;
  logic [1:0]  ym_addr;
  logic [7:0]  ym_din;
  logic        ym_cs_n, ym_wr_n;
  logic [7:0]  ym_dout = 8'h00;

  jt12_wrqueue #(
    .DEPTH_LOG2(DL), .WR_PULSE(WP), .POLL_WAIT(PW), .BUSY_TIMEOUT(BT)
  ) dut (
    .clk(clk), .rst(rst), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .full(full), .empty(empty), .level(level), .drop(drop), .timeout(timeout),
    .idle(idle), .ym_addr(ym_addr), .ym_din(ym_din), .ym_cs_n(ym_cs_n),
    .ym_wr_n(ym_wr_n), .ym_dout(ym_dout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] addr;
    logic [7:0] din;
    int         polls;
    int         to;
  } exp_t;

  exp_t exp_q[$];
  int   busy_q[$];
  int   checks = 0;
  int   errors = 0;
  int   accepted = 0;
  int   completed = 0;
  int   drop_cnt = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Push one entry at a negedge. busy = number of busy samples the jt12
  // model reports before releasing (data port only); accept = whether the
  // FIFO is expected to take it. Expected poll length and timeout come
  // straight from the busy-poll rules.
  task automatic applyStimulus(input logic [1:0] a, input logic [7:0] d, input int busy, input bit accept);
    exp_t e;
    int   eff;
    cpu_wr   = 1'b1;
    cpu_addr = a;
    cpu_din  = d;
    if (accept) begin
      eff     = (busy > BT) ? BT : busy;
      e.addr  = a;
      e.din   = d;
      e.polls = a[0] ? PW * (eff + 1) : 0;
      e.to    = (a[0] && busy > BT) ? 1 : 0;
      exp_q.push_back(e);
      if (a[0]) busy_q.push_back(busy);
      accepted++;
    end
    @(negedge clk);
    cpu_wr = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while ((exp_q.size() != 0 || !idle) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_in_time", n < 3000, 1);
  endtask

  // jt12 status model: counts poll cycles and reports busy until the
  // requested number of samples has been taken in this poll session.
  int b_cur, samples, pc;
  bit in_poll;
  always @(negedge clk) begin
    if (rst) begin
      in_poll = 1'b0;
      ym_dout = 8'h00;
    end else if (!ym_cs_n && ym_wr_n) begin
      if (!in_poll) begin
        in_poll = 1'b1;
        b_cur   = (busy_q.size() != 0) ? busy_q.pop_front() : 0;
        samples = 0;
        pc      = 0;
      end
      pc++;
      ym_dout = {(samples < b_cur), 7'($urandom)};
      if (pc == PW) begin
        samples++;
        pc = 0;
      end
    end else begin
      in_poll = 1'b0;
      ym_dout = {1'b0, 7'($urandom)};
    end
  end

  // Monitor: assembles poll cycles, strobe cycles and timeout pulses into
  // one transaction, closed when cs_n rises after the write strobe.
  int         cur_wr, cur_polls, cur_to;
  logic [1:0] cur_addr;
  logic [7:0] cur_din;
  bit         unstable, bad_poll;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      cur_wr = 0; cur_polls = 0; cur_to = 0; unstable = 0; bad_poll = 0;
    end else begin
      if (drop) drop_cnt++;
      if (timeout) cur_to++;
      if (!ym_cs_n && ym_wr_n) begin
        cur_polls++;
        if (ym_addr != 2'b00) bad_poll = 1;
      end else if (!ym_cs_n && !ym_wr_n) begin
        if (cur_wr == 0) begin
          cur_addr = ym_addr;
          cur_din  = ym_din;
        end else if (ym_addr != cur_addr || ym_din != cur_din) begin
          unstable = 1;
        end
        cur_wr++;
      end else if (cur_wr > 0) begin
        checkOutput("write_was_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          checkOutput("wr_addr", cur_addr, e.addr);
          checkOutput("wr_din", cur_din, e.din);
          checkOutput("wr_pulse_len", cur_wr, WP);
          checkOutput("poll_cycles", cur_polls, e.polls);
          checkOutput("timeout_pulses", cur_to, e.to);
          checkOutput("bus_stable", {unstable, bad_poll}, 0);
        end
        completed++;
        cur_wr = 0; cur_polls = 0; cur_to = 0; unstable = 0; bad_poll = 0;
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int drops0, n;
    bit [1:0] ra;
    int rb;
    rst = 1'b1; cpu_wr = 1'b0; cpu_addr = 2'b00; cpu_din = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_cs_wr", {ym_cs_n, ym_wr_n}, 2'b11);
    checkOutput("rst_addr_din", {ym_addr, ym_din}, 10'h000);
    checkOutput("rst_level", level, 0);
    checkOutput("rst_flags", {empty, full, drop, timeout, idle}, 5'b10001);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    $display("[TB] address-port write timing");
    applyStimulus(2'd0, 8'h28, 0, 1);
    checkOutput("c1_idle", idle, 0);
    checkOutput("c1_cs", ym_cs_n, 1);
    @(negedge clk);
    checkOutput("c2_strobe", {ym_cs_n, ym_wr_n, ym_addr, ym_din}, {2'b00, 2'd0, 8'h28});
    @(negedge clk);
    checkOutput("c3_strobe", {ym_cs_n, ym_wr_n}, 2'b00);
    @(negedge clk);
    checkOutput("c4_gap", {ym_cs_n, ym_wr_n}, 2'b11);
    @(negedge clk);
    checkOutput("c5_idle", idle, 1);
    waitDrain();

    $display("[TB] data-port write, not busy");
    applyStimulus(2'd1, 8'hF0, 0, 1);
    @(negedge clk);
    checkOutput("c2_poll", {ym_cs_n, ym_wr_n, ym_addr}, {2'b01, 2'd0});
    @(negedge clk);
    checkOutput("c3_poll", {ym_cs_n, ym_wr_n, ym_addr}, {2'b01, 2'd0});
    @(negedge clk);
    checkOutput("c4_write", {ym_cs_n, ym_wr_n, ym_addr, ym_din, timeout}, {2'b00, 2'd1, 8'hF0, 1'b0});
    @(negedge clk);
    checkOutput("c5_write", {ym_cs_n, ym_wr_n}, 2'b00);
    @(negedge clk);
    checkOutput("c6_gap", ym_cs_n, 1);
    waitDrain();

    $display("[TB] busy for 10 samples, then forced-write after timeout");
    applyStimulus(2'd1, 8'h55, 10, 1);
    waitDrain();
    applyStimulus(2'd1, 8'hA7, 1000, 1);
    waitDrain();

    $display("[TB] overflow while sequencer is stalled");
    applyStimulus(2'd1, 8'h3C, 1000, 1);
    n = 0;
    while (!(!ym_cs_n && ym_wr_n) && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("stall_reached_poll", n < 20, 1);
    drops0 = drop_cnt;
    for (int i = 0; i < DEPTH; i++) applyStimulus(2'($urandom), 8'($urandom), 0, 1);
    checkOutput("burst_level", level, DEPTH);
    checkOutput("burst_full", full, 1);
    applyStimulus(2'($urandom), 8'($urandom), 0, 0);
    checkOutput("drop_pulse", drop, 1);
    @(negedge clk);
    checkOutput("drop_one_cycle", drop, 0);
    waitDrain();
    checkOutput("drop_count", drop_cnt - drops0, 1);

    $display("[TB] reset during a write");
    applyStimulus(2'd0, 8'h11, 0, 1);
    applyStimulus(2'd0, 8'h22, 0, 1);
    applyStimulus(2'd1, 8'h33, 0, 1);
    n = 0;
    while (ym_wr_n && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reached_write", n < 20, 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    busy_q.delete();
    #1;
    checkOutput("rst_abort_cs_wr", {ym_cs_n, ym_wr_n}, 2'b11);
    checkOutput("rst_abort_fifo", {level, empty}, {5'd0, 1'b1});
    @(posedge clk);
    #2;
    rst = 1'b0;
    accepted = completed;
    @(negedge clk);
    applyStimulus(2'd0, 8'h44, 0, 1);
    waitDrain();

    $display("[TB] randomized traffic");
    drops0 = drop_cnt;
    for (int k = 0; k < 60; k++) begin
      n = 0;
      while ((accepted - completed) >= DEPTH && n < 2000) begin
        @(negedge clk);
        n++;
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      ra = 2'($urandom);
      rb = ($urandom_range(0, 9) == 9) ? BT + 2 : $urandom_range(0, 3);
      applyStimulus(ra, 8'($urandom), rb, 1);
    end
    waitDrain();
    checkOutput("random_no_drop", drop_cnt - drops0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jt12_wrqueue.md
Name: jt12_wrqueue

Overview:
- Write-queue and bus sequencer upstream of the jt12 core.
- Accepts CPU register writes as single-cycle pushes into a FIFO. Replays each write onto the jt12 bus pins (addr, din, cs_n, wr_n).
- Before every data-port write, polls the jt12 status byte and waits until the busy bit clears, so the CPU never has to poll busy itself.
- Runs on the same clock as jt12.

Parameters:
- DEPTH_LOG2, 4: FIFO holds 2**DEPTH_LOG2 entries.
- WR_PULSE, 2: number of cycles ym_cs_n and ym_wr_n are held low per write, 1..15.
- POLL_WAIT, 2: number of cycles in a status read before dout[7] is sampled, 1..15.
- BUSY_TIMEOUT, 1023: maximum busy-poll samples before a write is forced, 1..65535.

Ports:
- clk  in  1  system clock, same clock as jt12 clk
- rst  in  1  asynchronous reset, active-high
- cpu_wr  in  1  push strobe, one entry per high cycle
- cpu_addr  in  2  jt12 address for the entry (bit0=0 address port, bit0=1 data port)
- cpu_din  in  8  data for the entry
- full  out  1  FIFO full
- empty  out  1  FIFO empty
- level  out  DEPTH_LOG2+1  number of entries in the FIFO
- drop  out  1  one-cycle pulse when a push is rejected because the FIFO is full
- timeout  out  1  one-cycle pulse when a write is forced after a busy timeout
- idle  out  1  high when the FIFO is empty and the sequencer is in IDLE
- ym_addr  out  2  to jt12 addr
- ym_din  out  8  to jt12 din
- ym_cs_n  out  1  to jt12 cs_n
- ym_wr_n  out  1  to jt12 wr_n
- ym_dout  in  8  from jt12 dout; bit7 is busy

Behaviour:
- Reset (asynchronous, active-high):
  - FIFO pointers cleared; level=0, empty=1, full=0.
  - State=IDLE; ym_cs_n=1, ym_wr_n=1, ym_addr=0, ym_din=0.
  - drop=0, timeout=0, idle=1.
  - Reset asserted mid-write aborts the write; cs_n and wr_n rise asynchronously, and queued entries are lost.
- All outputs are registered.
- FIFO:
  - Entry width is 10 bits: {addr, din}. Storage is circular and pointers wrap modulo 2**DEPTH_LOG2.
  - A push with full=1 is rejected, and drop pulses on the following cycle. The full test uses the pre-pop value, so a push and a pop in the same cycle while full still drops the push.
  - A push and a pop in the same cycle while not full leave level unchanged.
  - An entry pushed at cycle N is visible to the sequencer at cycle N+1.
- Sequencer FSM:
  - IDLE (cs_n=1, wr_n=1): if !empty, pop the head and latch it into an internal entry register. If the entry's addr[0]=0, go to WRITE; otherwise clear the poll timer and go to POLL.
  - POLL (cs_n=0, wr_n=1, ym_addr=2'b00): ym_dout[7] is sampled on the POLL_WAIT-th cycle.
    - If the sample is 0, go to WRITE.
    - If the sample is 1 and the timer is below BUSY_TIMEOUT, increment the timer and restart the POLL_WAIT count while staying in POLL.
    - If the sample is 1 and the timer equals BUSY_TIMEOUT, pulse timeout and go to WRITE.
  - WRITE (cs_n=0, wr_n=0, ym_addr/ym_din = latched entry): held for exactly WRITE_PULSE cycles, then go to GAP.
  - GAP (cs_n=1, wr_n=1, one cycle): go to IDLE.
- ym_din and ym_addr are stable for the whole WRITE window. They change only on entering WRITE or POLL.
- Timing for an address-port write with WR_PULSE=2: pushed at cycle 0, IDLE pops at cycle 1, cs_n/wr_n are low at cycles 2–3, GAP at cycle 4, next pop at cycle 5. Sustained throughput is one address write per 4 cycles.
- Timing for a data-port write that is not busy, with POLL_WAIT=2: POLL at cycles 2–3, WRITE at cycles 4–5, GAP at cycle 6.
- Order is strictly preserved; the sequencer never reorders address and data entries.
- idle = empty & (state==IDLE), registered.

Test Plan:
- Reset then push (addr=0, din=0x28); check ym_cs_n/ym_wr_n low on cycles 2–3 with ym_addr=0, ym_din=0x28; then idle=1 by cycle 5.
- Push (1,0xF0) with ym_dout=0x00; check POLL for 2 cycles with ym_addr=0 and wr_n=1, then WRITE with ym_addr=1, ym_din=0xF0 for 2 cycles, and timeout=0.
- Push (1,0x55) and hold ym_dout[7]=1 for 10 poll samples, then 0; check no write before busy falls, the write follows within POLL_WAIT+1 cycles, and timeout=0.
- Use BUSY_TIMEOUT=3 with ym_dout[7] stuck at 1; check a single timeout pulse after the 4th busy sample and a write with the correct data.
- Make 17 back-to-back pushes with DEPTH_LOG2=4 while the sequencer is stalled by busy; check level peaks at 16, full=1, exactly one drop pulse, and 16 writes emitted in push order with the 17th absent.
- Assert rst mid-WRITE; check cs_n=1, wr_n=1 immediately, level=0 and empty=1; the next push completes normally.
